// File: rtl/hazard_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// the priority-decode classes and the enable/flush bundle each class drives.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    // Decode classes, listed highest priority first.
    typedef enum logic [2:0] {
        DEC_HALT    = 3'd0,
        DEC_FREEZE  = 3'd1,
        DEC_BRANCH  = 3'd2,
        DEC_LOADUSE = 3'd3,
        DEC_NORMAL  = 3'd4
    } dec_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctl_t;

    localparam ctl_t CTL_STOP    = 7'b00000_00;
    localparam ctl_t CTL_BRANCH  = 7'b11111_11;
    localparam ctl_t CTL_LOADUSE = 7'b00111_01;
    localparam ctl_t CTL_NORMAL  = 7'b11111_00;

    // Map a decode class to the register enable/flush pattern it produces.
    function automatic ctl_t dec_ctl(input dec_t d);
        case (d)
            DEC_HALT,
            DEC_FREEZE:  dec_ctl = CTL_STOP;
            DEC_BRANCH:  dec_ctl = CTL_BRANCH;
            DEC_LOADUSE: dec_ctl = CTL_LOADUSE;
            default:     dec_ctl = CTL_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on reset, counts on inc, holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment until every bit is set, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use bubbles,
// taken-branch squashes, data-memory freezes, halt and memory-timeout error.
// Optional build macro HAZARD_PERF_EN adds saturating event counters
// (perf_lu, perf_br, perf_mem) of width CNT_W.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int WAIT_MAX = 255
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_vld,
    input  logic              id_rt_vld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_wr_en,
    input  logic              br_taken,
    input  logic              dmem_req,
    input  logic              dmem_done,
    input  logic              wb_halt,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              halted,
    output logic              err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_lu,
    output logic [CNT_W-1:0]  perf_br,
    output logic [CNT_W-1:0]  perf_mem
`endif
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    state_t         state, state_nxt;
    logic [WCW-1:0] wcnt, wcnt_nxt, wcnt_inc;
    logic           err_set;
    logic           lu_hit, mem_stall;
    dec_t           dec;
    ctl_t           ctl;

    assign lu_hit    = ex_is_load & ex_wr_en &
                       ((id_rs_vld & (id_rs == ex_rd)) | (id_rt_vld & (id_rt == ex_rd)));
    assign mem_stall = dmem_req & ~dmem_done;
    assign wcnt_inc  = wcnt + 1'b1;

    // State, wait counter and the registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            wcnt   <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            halted <= (state_nxt == HALTED);
            err    <= err | err_set;
        end
    end

    // Next state: a stalled cycle counts toward the timeout (the counter is
    // zero in RUN, so the first stalled cycle counts as 1); wb_halt is only
    // honoured when WB is actually advancing, i.e. in RUN and not frozen.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        err_set   = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    wcnt_nxt = wcnt_inc;
                    if (wcnt_inc == WCW'(WAIT_MAX)) begin
                        state_nxt = HALTED;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = MEM_WAIT;
                    end
                end else if (state == MEM_WAIT) begin
                    if (dmem_done) begin
                        state_nxt = RUN;
                        wcnt_nxt  = '0;
                    end
                end else if (wb_halt) begin
                    state_nxt = HALTED;
                end
            end
            default: state_nxt = HALTED;
        endcase
    end

    // Zero-latency priority decode of state and hazards into enables.
    always_comb begin
        if (state == HALTED)
            dec = DEC_HALT;
        else if (mem_stall)
            dec = DEC_FREEZE;
        else if (br_taken)
            dec = DEC_BRANCH;
        else if (lu_hit)
            dec = DEC_LOADUSE;
        else
            dec = DEC_NORMAL;
        ctl = dec_ctl(dec);
    end

    assign pc_en        = ctl.pc_en;
    assign if_id_en     = ctl.if_id_en;
    assign id_ex_en     = ctl.id_ex_en;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign mem_wb_en    = ctl.mem_wb_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_bubble = ctl.id_ex_bubble;

`ifdef HAZARD_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_perf_lu (
        .clk   (clk),
        .rst   (rst),
        .inc   (dec == DEC_LOADUSE),
        .count (perf_lu)
    );

    sat_counter #(.WIDTH(CNT_W)) u_perf_br (
        .clk   (clk),
        .rst   (rst),
        .inc   (dec == DEC_BRANCH),
        .count (perf_br)
    );

    sat_counter #(.WIDTH(CNT_W)) u_perf_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (dec == DEC_FREEZE),
        .count (perf_mem)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios with a queue of expected
// output words compared at the mid-cycle sample point.
module tb_hazard_ctrl;

    localparam int REG_AW   = 3;
    localparam int WAIT_MAX = 8;

    // Output word: {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, halted, err}
    localparam logic [8:0] O_RUN  = 9'b11111_00_00;
    localparam logic [8:0] O_LU   = 9'b00111_01_00;
    localparam logic [8:0] O_BR   = 9'b11111_11_00;
    localparam logic [8:0] O_FRZ  = 9'b00000_00_00;
    localparam logic [8:0] O_HLT  = 9'b00000_00_10;
    localparam logic [8:0] O_HERR = 9'b00000_00_11;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic              id_rs_vld, id_rt_vld, ex_is_load, ex_wr_en;
    logic              br_taken, dmem_req, dmem_done, wb_halt;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic              if_id_flush, id_ex_bubble, halted, err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    logic [3:0] perf_lu, perf_br, perf_mem;

    hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_done(dmem_done),
        .wb_halt(wb_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .err(err),
        .perf_lu(perf_lu), .perf_br(perf_br), .perf_mem(perf_mem)
    );
`else
    hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_done(dmem_done),
        .wb_halt(wb_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .err(err)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
        ex_rd = '0; ex_is_load = 1'b0; ex_wr_en = 1'b0;
        br_taken = 1'b0; dmem_req = 1'b0; dmem_done = 1'b0; wb_halt = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with inputs already applied:
    // push the expectation, sample mid-cycle, compare, advance past next edge.
    task automatic step(input string tag, input logic [8:0] expv);
        logic [8:0] obs;
        logic [8:0] e;
        sb.push_back(expv);
        #5;
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_bubble, halted, err};
        e = sb.pop_front();
        chk(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step("reset", O_RUN);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        step("reset_state", O_RUN);
        rst = 1'b0;
        step("idle", O_RUN);

        // Load-use via rs: one bubble, then release once EX holds the bubble.
        ex_rd = 3'd3; ex_is_load = 1'b1; ex_wr_en = 1'b1; id_rs = 3'd3; id_rs_vld = 1'b1;
        step("lu_rs", O_LU);
        ex_is_load = 1'b0; ex_wr_en = 1'b0;
        step("lu_release", O_RUN);

        // rt match only counts when rt is actually read.
        idle(); ex_rd = 3'd5; ex_is_load = 1'b1; ex_wr_en = 1'b1; id_rt = 3'd5;
        step("lu_rt_novld", O_RUN);
        id_rt_vld = 1'b1;
        step("lu_rt", O_LU);
        ex_wr_en = 1'b0;
        step("lu_no_wr", O_RUN);
        idle(); ex_rd = 3'd2; ex_wr_en = 1'b1; id_rs = 3'd2; id_rs_vld = 1'b1;
        step("lu_not_load", O_RUN);
        ex_is_load = 1'b1; id_rs = 3'd6;
        step("lu_diff_reg", O_RUN);

        // Branch wins over a simultaneous load-use hit.
        id_rs = 3'd2; br_taken = 1'b1;
        step("br_over_lu", O_BR);
        idle(); br_taken = 1'b1;
        step("br_alone", O_BR);

        // 4-cycle access, done on the 4th: three frozen cycles.
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem4_frz", O_FRZ);
        dmem_done = 1'b1;
        step("mem4_done", O_RUN);
        idle();
        step("mem4_after", O_RUN);

        // Seven stalls must not time out if the counter cleared on resume.
        dmem_req = 1'b1;
        for (int i = 0; i < 7; i++) step("mem7_frz", O_FRZ);
        dmem_done = 1'b1;
        step("mem7_done", O_RUN);
        idle();
        step("mem7_after", O_RUN);

        // Request completing in its own cycle: no stall.
        dmem_req = 1'b1; dmem_done = 1'b1;
        step("mem_same_cyc", O_RUN);
        idle();
        step("mem_same_after", O_RUN);

        // wb_halt while frozen is ignored (both in RUN and MEM_WAIT).
        dmem_req = 1'b1; wb_halt = 1'b1;
        step("halt_frz_run", O_FRZ);
        step("halt_frz_wait", O_FRZ);
        wb_halt = 1'b0; dmem_done = 1'b1;
        step("halt_frz_done", O_RUN);
        idle();
        step("halt_ignored", O_RUN);

        // wb_halt pulse: halted next cycle, everything stops until reset.
        wb_halt = 1'b1;
        step("halt_pulse", O_RUN);
        idle();
        step("halted", O_HLT);
        br_taken = 1'b1;
        step("halted_br", O_HLT);
        idle(); dmem_req = 1'b1;
        step("halted_mem", O_HLT);
        idle();
        rst = 1'b1;
        step("async_rst_halt", O_RUN);
        rst = 1'b0;
        step("post_rst", O_RUN);

        // Hung access: err and halt after WAIT_MAX stalled cycles.
        dmem_req = 1'b1;
        for (int i = 0; i < WAIT_MAX; i++) step("tmo_frz", O_FRZ);
        step("tmo_err", O_HERR);
        step("tmo_hold", O_HERR);
        dmem_req = 1'b0;
        step("tmo_sticky", O_HERR);
        rst = 1'b1;
        step("async_rst_err", O_RUN);
        rst = 1'b0;

        // Reset mid-stall clears state and counter immediately.
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) step("mid_frz", O_FRZ);
        rst = 1'b1;
        step("mid_rst_frz", O_FRZ);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step("mid_post_frz", O_FRZ);
        dmem_done = 1'b1;
        step("mid_post_done", O_RUN);
        idle();

`ifdef HAZARD_PERF_EN
        do_reset();
        br_taken = 1'b1;
        for (int i = 0; i < 20; i++) step("perf_br_cyc", O_BR);
        idle();
        step("perf_idle", O_RUN);
        chk("perf_br_sat", 32'(perf_br), 32'd15);
        chk("perf_lu_zero", 32'(perf_lu), 32'd0);
        chk("perf_mem_zero", 32'(perf_mem), 32'd0);
        ex_rd = 3'd1; ex_is_load = 1'b1; ex_wr_en = 1'b1; id_rs = 3'd1; id_rs_vld = 1'b1;
        step("perf_lu_cyc", O_LU);
        idle(); dmem_req = 1'b1;
        step("perf_mem_cyc", O_FRZ);
        step("perf_mem_cyc", O_FRZ);
        dmem_done = 1'b1;
        step("perf_mem_done", O_RUN);
        idle();
        chk("perf_lu_one", 32'(perf_lu), 32'd1);
        chk("perf_mem_two", 32'(perf_mem), 32'd2);
`else
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
